// File: rtl/deconv_col_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : deconv_feed_pkg
//  Purpose  : Shared definitions for the deconv column feeder: FSM state
//             encoding and the location/width of the count fields inside the
//             configuration registers.
//  Revision : 1.0  initial release
// ============================================================================
package deconv_feed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_W   = 3'd1,
        ST_REPLAY    = 3'd2,
        ST_LOAD_IP   = 3'd3,
        ST_WAIT_CORE = 3'd4,
        ST_DONE      = 3'd5
    } feed_state_e;

    // Count fields (N_CH, N_COL) sit in the low half of each config register.
    localparam int CFG_CNT_LSB = 0;
    localparam int CFG_CNT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/deconv_col_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : deconv_col_feeder_if
//  Purpose  : Bundles the feeder's data-path signals: the two upstream
//             valid/ready column streams, the load bus towards the deconv
//             core, and the core's feedback requests.
//  Ports    : master - the column feeder (consumes streams, drives load bus)
//             slave  - the environment (upstream sources + deconv core)
//  Revision : 1.0  initial release
// ============================================================================
interface deconv_col_feeder_if #(
    parameter int PIX_WIDTH       = 8,
    parameter int SIZE_OF_WEIGHT  = 5,
    parameter int SIZE_OF_FEATURE = 2
);
    // upstream weight column stream
    logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]  s_wght_data;
    logic                                 s_wght_valid;
    logic                                 s_wght_ready;
    // upstream feature column stream
    logic [PIX_WIDTH*SIZE_OF_FEATURE-1:0] s_feat_data;
    logic                                 s_feat_valid;
    logic                                 s_feat_ready;
    // load bus into the core
    logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]  o_weight_col;
    logic [PIX_WIDTH*SIZE_OF_FEATURE-1:0] o_feature_map_col;
    logic                                 o_enable_loadw;
    logic                                 o_enable_loadip;
    // core feedback
    logic                                 i_en_prcs_new_wcoln;
    logic                                 i_en_prcs_new_chnl;
    logic                                 i_en_fifo_loop;

    modport master (
        input  s_wght_data, s_wght_valid,
        output s_wght_ready,
        input  s_feat_data, s_feat_valid,
        output s_feat_ready,
        output o_weight_col, o_feature_map_col, o_enable_loadw, o_enable_loadip,
        input  i_en_prcs_new_wcoln, i_en_prcs_new_chnl, i_en_fifo_loop
    );

    modport slave (
        output s_wght_data, s_wght_valid,
        input  s_wght_ready,
        output s_feat_data, s_feat_valid,
        input  s_feat_ready,
        input  o_weight_col, o_feature_map_col, o_enable_loadw, o_enable_loadip,
        output i_en_prcs_new_wcoln, i_en_prcs_new_chnl, i_en_fifo_loop
    );
endinterface
`default_nettype wire

// File: rtl/deconv_col_feeder_wloop_buf.sv
`default_nettype none
// ============================================================================
//  Module   : deconv_wloop_buf
//  Purpose  : Kernel loopback buffer. DEPTH x WIDTH register file with an
//             auto-incrementing write pointer and a wrapping read pointer.
//             Reads are non-destructive, so a cached kernel can be replayed
//             any number of times. Only the pointers are reset.
//  Ports    : i_clk, i_rst_n      clock, synchronous active-low reset
//             i_wr_en, i_wr_data  write i_wr_data at o_wr_ptr, advance pointer
//             i_wr_clr            return the write pointer to 0
//             i_rd_en             advance the read pointer (wraps to 0)
//             o_wr_ptr, o_rd_ptr  current pointers
//             o_rd_data           entry at o_rd_ptr (combinational read)
//  Revision : 1.0  initial release
// ============================================================================
module deconv_wloop_buf #(
    parameter  int DEPTH = 5,
    parameter  int WIDTH = 40,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic             i_wr_clr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [WIDTH-1:0] o_rd_data
);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (i_wr_clr) begin
            wr_ptr_d = '0;
        end else if (i_wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        rd_ptr_d = rd_ptr_q;
        if (i_rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset: contents are always rewritten before replay.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_wr_ptr  = wr_ptr_q;
    assign o_rd_ptr  = rd_ptr_q;
    assign o_rd_data = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/deconv_col_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : deconv_col_feeder
//  Purpose  : Transmit side of the deconv column-load interface. Pulls weight
//             and feature-map columns from upstream streams and issues them
//             to the deconv core with one-cycle load strobes, reacting to the
//             core's column / channel / loopback requests. The kernel of the
//             current channel is cached so loopback replays need no refetch.
//  Ports    : i_clk, i_rst_n        clock, synchronous active-low reset
//             i_start               pulse: latch config and start a job
//             i_param_cfg_feature   [15:0] feature columns per channel
//             i_param_cfg_weight    [15:0] channel count
//             bus (master)          upstream streams, core load bus, feedback
//             o_busy                job in progress
//             o_done                one-cycle pulse at job end
//  Revision : 1.0  initial release
// ============================================================================
module deconv_col_feeder
    import deconv_feed_pkg::*;
#(
    parameter int SIZE_OF_WEIGHT  = 5,
    parameter int SIZE_OF_FEATURE = 2,
    parameter int PIX_WIDTH       = 8,
    parameter int REG_WIDTH       = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [REG_WIDTH-1:0] i_param_cfg_feature,
    input  logic [REG_WIDTH-1:0] i_param_cfg_weight,
    deconv_col_feeder_if.master  bus,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int WCOL_W = PIX_WIDTH * SIZE_OF_WEIGHT;
    localparam int FCOL_W = PIX_WIDTH * SIZE_OF_FEATURE;
    localparam int PTR_W  = (SIZE_OF_WEIGHT > 1) ? $clog2(SIZE_OF_WEIGHT) : 1;

    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(SIZE_OF_WEIGHT - 1);
    localparam logic [CFG_CNT_W-1:0] CNT_ONE  = CFG_CNT_W'(1);

    // ---------------------------------------------------------------- config
    logic [CFG_CNT_W-1:0] w_cfg_n_ch;
    logic [CFG_CNT_W-1:0] w_cfg_n_col;
    logic                 unused_cfg_bits;

    assign w_cfg_n_ch      = i_param_cfg_weight[CFG_CNT_LSB +: CFG_CNT_W];
    assign w_cfg_n_col     = i_param_cfg_feature[CFG_CNT_LSB +: CFG_CNT_W];
    assign unused_cfg_bits = ^{i_param_cfg_weight[REG_WIDTH-1:CFG_CNT_W],
                               i_param_cfg_feature[REG_WIDTH-1:CFG_CNT_W]};

    // ------------------------------------------------------------- state
    feed_state_e          state_q,   state_d;
    logic [CFG_CNT_W-1:0] n_ch_q,    n_ch_d;
    logic [CFG_CNT_W-1:0] n_col_q,   n_col_d;
    logic [CFG_CNT_W-1:0] ch_cnt_q,  ch_cnt_d;
    logic [CFG_CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [WCOL_W-1:0]    wcol_q,    wcol_d;
    logic [FCOL_W-1:0]    fcol_q,    fcol_d;
    logic                 loadw_q,   loadw_d;
    logic                 loadip_q,  loadip_d;
    logic                 wready_q,  wready_d;
    logic                 fready_q,  fready_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    // ----------------------------------------------------- loopback buffer
    logic              w_buf_wr_en;
    logic              w_buf_wr_clr;
    logic              w_buf_rd_en;
    logic [PTR_W-1:0]  w_buf_wr_ptr;
    logic [PTR_W-1:0]  w_buf_rd_ptr;
    logic [WCOL_W-1:0] w_buf_rd_data;

    deconv_wloop_buf #(
        .DEPTH (SIZE_OF_WEIGHT),
        .WIDTH (WCOL_W)
    ) u_wloop_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_buf_wr_en),
        .i_wr_clr  (w_buf_wr_clr),
        .i_wr_data (bus.s_wght_data),
        .i_rd_en   (w_buf_rd_en),
        .o_wr_ptr  (w_buf_wr_ptr),
        .o_rd_ptr  (w_buf_rd_ptr),
        .o_rd_data (w_buf_rd_data)
    );

    // Ready is registered, so a handshake is valid & the ready we present.
    logic w_wght_accept;
    logic w_feat_accept;
    logic w_last_col;

    assign w_wght_accept = bus.s_wght_valid & wready_q;
    assign w_feat_accept = bus.s_feat_valid & fready_q;
    assign w_last_col    = (col_cnt_q == n_col_q - CNT_ONE);

    // ------------------------------------------------------- next state
    always_comb begin
        state_d      = state_q;
        n_ch_d       = n_ch_q;
        n_col_d      = n_col_q;
        ch_cnt_d     = ch_cnt_q;
        col_cnt_d    = col_cnt_q;
        wcol_d       = wcol_q;
        fcol_d       = fcol_q;
        loadw_d      = 1'b0;
        loadip_d     = 1'b0;
        w_buf_wr_en  = 1'b0;
        w_buf_wr_clr = 1'b0;
        w_buf_rd_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    n_ch_d       = w_cfg_n_ch;
                    n_col_d      = w_cfg_n_col;
                    ch_cnt_d     = '0;
                    col_cnt_d    = '0;
                    w_buf_wr_clr = 1'b1;
                    if (w_cfg_n_ch == '0 || w_cfg_n_col == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH_W;
                    end
                end
            end

            ST_FETCH_W: begin
                if (w_wght_accept) begin
                    w_buf_wr_en = 1'b1;
                    wcol_d      = bus.s_wght_data;
                    loadw_d     = 1'b1;
                    if (w_buf_wr_ptr == PTR_LAST) begin
                        state_d = ST_LOAD_IP;
                    end
                end
            end

            ST_REPLAY: begin
                w_buf_rd_en = 1'b1;
                wcol_d      = w_buf_rd_data;
                loadw_d     = 1'b1;
                if (w_buf_rd_ptr == PTR_LAST) begin
                    state_d = ST_WAIT_CORE;
                end
            end

            ST_LOAD_IP: begin
                if (w_feat_accept) begin
                    fcol_d   = bus.s_feat_data;
                    loadip_d = 1'b1;
                    state_d  = ST_WAIT_CORE;
                end
            end

            ST_WAIT_CORE: begin
                // One request per cycle; channel advance beats loopback,
                // which beats a plain column advance.
                if (bus.i_en_prcs_new_chnl || (bus.i_en_prcs_new_wcoln && w_last_col)) begin
                    col_cnt_d = '0;
                    ch_cnt_d  = ch_cnt_q + CNT_ONE;
                    if (ch_cnt_q == n_ch_q - CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        w_buf_wr_clr = 1'b1;
                        state_d      = ST_FETCH_W;
                    end
                end else if (bus.i_en_fifo_loop) begin
                    state_d = ST_REPLAY;
                end else if (bus.i_en_prcs_new_wcoln) begin
                    col_cnt_d = col_cnt_q + CNT_ONE;
                    state_d   = ST_LOAD_IP;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready follows the upcoming state so it drops right after the last
        // required accept and never admits a surplus beat.
        wready_d = (state_d == ST_FETCH_W);
        fready_d = (state_d == ST_LOAD_IP);
        busy_d   = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_d   = (state_q == ST_DONE);
    end

    // ---------------------------------------------------------- registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            n_ch_q    <= '0;
            n_col_q   <= '0;
            ch_cnt_q  <= '0;
            col_cnt_q <= '0;
            wcol_q    <= '0;
            fcol_q    <= '0;
            loadw_q   <= 1'b0;
            loadip_q  <= 1'b0;
            wready_q  <= 1'b0;
            fready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_ch_q    <= n_ch_d;
            n_col_q   <= n_col_d;
            ch_cnt_q  <= ch_cnt_d;
            col_cnt_q <= col_cnt_d;
            wcol_q    <= wcol_d;
            fcol_q    <= fcol_d;
            loadw_q   <= loadw_d;
            loadip_q  <= loadip_d;
            wready_q  <= wready_d;
            fready_q  <= fready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.s_wght_ready      = wready_q;
    assign bus.s_feat_ready      = fready_q;
    assign bus.o_weight_col      = wcol_q;
    assign bus.o_feature_map_col = fcol_q;
    assign bus.o_enable_loadw    = loadw_q;
    assign bus.o_enable_loadip   = loadip_q;
    assign o_busy                = busy_q;
    assign o_done                = done_q;

endmodule
`default_nettype wire

// File: tb/tb_deconv_col_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_deconv_col_feeder
//  Purpose  : Self-checking bench for deconv_col_feeder. Acts as upstream
//             sources and as the deconv core; expected column order is
//             derived from channel/column arithmetic over the source queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_deconv_col_feeder;
    localparam int SOW = 5;
    localparam int SOF = 2;
    localparam int PIX = 8;
    localparam int RW  = 32;
    localparam int WW  = PIX * SOW;
    localparam int FW  = PIX * SOF;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [RW-1:0] cfg_feat = '0;
    logic [RW-1:0] cfg_wght = '0;
    logic          busy;
    logic          done;

    deconv_col_feeder_if #(.PIX_WIDTH(PIX), .SIZE_OF_WEIGHT(SOW), .SIZE_OF_FEATURE(SOF)) bus ();

    deconv_col_feeder #(
        .SIZE_OF_WEIGHT  (SOW),
        .SIZE_OF_FEATURE (SOF),
        .PIX_WIDTH       (PIX),
        .REG_WIDTH       (RW)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_start             (start),
        .i_param_cfg_feature (cfg_feat),
        .i_param_cfg_weight  (cfg_wght),
        .bus                 (bus),
        .o_busy              (busy),
        .o_done              (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------- upstream
    logic [WW-1:0] w_src[$];
    logic [FW-1:0] f_src[$];
    int  w_idx   = 0;
    int  f_idx   = 0;
    int  vmode   = 0;
    int  cyc     = 0;
    bit  src_rst = 1'b1;
    bit  w_acc   = 1'b0;
    bit  f_acc   = 1'b0;
    bit  vw, vf;

    always @(posedge clk) begin
        w_acc <= bus.s_wght_valid & bus.s_wght_ready;
        f_acc <= bus.s_feat_valid & bus.s_feat_ready;
    end

    always @(negedge clk) begin
        cyc++;
        if (src_rst) begin
            w_idx = 0;
            f_idx = 0;
        end else begin
            if (w_acc) w_idx++;
            if (f_acc) f_idx++;
        end
        case (vmode)
            0:       begin vw = 1'b1;   vf = 1'b1;   end
            1:       begin vw = cyc[0]; vf = ~cyc[0]; end
            default: begin vw = 1'($urandom_range(0, 1)); vf = 1'($urandom_range(0, 1)); end
        endcase
        bus.s_wght_valid = !src_rst && (w_idx < w_src.size()) && vw;
        bus.s_wght_data  = (w_idx < w_src.size()) ? w_src[w_idx] : '0;
        bus.s_feat_valid = !src_rst && (f_idx < f_src.size()) && vf;
        bus.s_feat_data  = (f_idx < f_src.size()) ? f_src[f_idx] : '0;
    end

    // ----------------------------------------------------------- monitor
    logic [WW-1:0] obs_w[$];
    logic [FW-1:0] obs_ip[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_enable_loadw)  obs_w.push_back(bus.o_weight_col);
            if (bus.o_enable_loadip) obs_ip.push_back(bus.o_feature_map_col);
            if (done)                done_cnt++;
        end
    end

    // ----------------------------------------------------------- helpers
    function automatic logic [WW-1:0] rand_w();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WW-1:0];
    endfunction

    function automatic logic [FW-1:0] rand_f();
        logic [31:0] r;
        r = $urandom();
        return r[FW-1:0];
    endfunction

    function automatic logic [WW-1:0] seq_w(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {SOW{b}};
    endfunction

    task automatic get_w(output logic [WW-1:0] v, output bit ok);
        int t = 0;
        v  = '0;
        ok = 1'b0;
        while (obs_w.size() == 0 && t < 200) begin @(negedge clk); #1; t++; end
        if (obs_w.size() > 0) begin v = obs_w.pop_front(); ok = 1'b1; end
        else check("timeout_loadw", 64'd0, 64'd1);
    endtask

    task automatic get_ip(output logic [FW-1:0] v, output bit ok);
        int t = 0;
        v  = '0;
        ok = 1'b0;
        while (obs_ip.size() == 0 && t < 200) begin @(negedge clk); #1; t++; end
        if (obs_ip.size() > 0) begin v = obs_ip.pop_front(); ok = 1'b1; end
        else check("timeout_loadip", 64'd0, 64'd1);
    endtask

    task automatic pulse_fb(input bit chnl, input bit wcoln, input bit loop);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        #1;
        bus.i_en_prcs_new_chnl  = chnl;
        bus.i_en_prcs_new_wcoln = wcoln;
        bus.i_en_fifo_loop      = loop;
        @(negedge clk);
        #1;
        bus.i_en_prcs_new_chnl  = 1'b0;
        bus.i_en_prcs_new_wcoln = 1'b0;
        bus.i_en_fifo_loop      = 1'b0;
    endtask

    function automatic int pick_act();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 4) return 0;       // wcoln
        if (r == 5) return 1;       // new channel
        if (r <= 7) return 2;       // loopback
        if (r == 8) return 3;       // wcoln + new channel
        return 4;                   // loopback + wcoln
    endfunction

    task automatic prep_sources(input int nw, input int nf, input bit seq, input int vm);
        src_rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        w_src.delete();
        f_src.delete();
        obs_w.delete();
        obs_ip.delete();
        for (int i = 0; i < nw; i++) w_src.push_back(seq ? seq_w(i + 1) : rand_w());
        for (int i = 0; i < nf; i++) f_src.push_back(rand_f());
        vmode   = vm;
        src_rst = 1'b0;
    endtask

    task automatic pulse_start(input int nch, input int ncol);
        cfg_wght = {16'($urandom()), 16'(nch)};
        cfg_feat = {16'($urandom()), 16'(ncol)};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // act_mode: 0 random, 1 always wcoln, 2 first loopback, 3 first wcoln+chnl
    task automatic run_job(input int nch, input int ncol, input int vm, input int act_mode, input bit seq);
        logic [WW-1:0] v;
        logic [FW-1:0] fv;
        bit  ok, first, adv, c_ch, c_wc, c_lp;
        int  fexp, col, act, d0, widx0, t;
        prep_sources(nch * SOW + 3, nch * ncol + 3, seq, vm);
        d0    = done_cnt;
        fexp  = 0;
        first = 1'b1;
        pulse_start(nch, ncol);
        for (int ch = 0; ch < nch; ch++) begin
            for (int k = 0; k < SOW; k++) begin
                get_w(v, ok);
                if (ok) check("w_fetch", 64'(v), 64'(w_src[ch * SOW + k]));
            end
            if (ch == 0) check("busy_run", 64'(busy), 64'd1);
            col = 0;
            adv = 1'b0;
            get_ip(fv, ok);
            if (ok) check("ip_col", 64'(fv), 64'(f_src[fexp]));
            fexp++;
            while (!adv) begin
                if (act_mode == 1)               act = 0;
                else if (first && act_mode == 2) act = 2;
                else if (first && act_mode == 3) act = 3;
                else                             act = pick_act();
                first = 1'b0;
                c_ch  = (act == 1) || (act == 3);
                c_wc  = (act == 0) || (act == 3) || (act == 4);
                c_lp  = (act == 2) || (act == 4);
                widx0 = w_idx;
                pulse_fb(c_ch, c_wc, c_lp);
                if (c_ch || (c_wc && col == ncol - 1)) begin
                    adv = 1'b1;
                end else if (c_lp) begin
                    for (int k = 0; k < SOW; k++) begin
                        get_w(v, ok);
                        if (ok) check("w_replay", 64'(v), 64'(w_src[ch * SOW + k]));
                    end
                    check("replay_no_accept", 64'(w_idx), 64'(widx0));
                end else begin
                    col++;
                    get_ip(fv, ok);
                    if (ok) check("ip_col", 64'(fv), 64'(f_src[fexp]));
                    fexp++;
                end
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 50) begin @(negedge clk); #1; t++; end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("no_extra_loadw", 64'(obs_w.size()), 64'd0);
        check("no_extra_loadip", 64'(obs_ip.size()), 64'd0);
        check("w_accepts", 64'(w_idx), 64'(nch * SOW));
        check("f_accepts", 64'(f_idx), 64'(fexp));
    endtask

    task automatic zero_job(input int nch, input int ncol);
        int d0, t;
        prep_sources(8, 4, 1'b0, 0);
        d0 = done_cnt;
        pulse_start(nch, ncol);
        t = 1;
        while (done_cnt == d0 && t < 20) begin @(negedge clk); #1; t++; end
        check("zero_done_latency", 64'(t), 64'd2);
        repeat (3) @(negedge clk);
        #1;
        check("zero_done_once", 64'(done_cnt - d0), 64'd1);
        check("zero_no_loadw", 64'(obs_w.size()), 64'd0);
        check("zero_no_loadip", 64'(obs_ip.size()), 64'd0);
        check("zero_no_accept", 64'(w_idx + f_idx), 64'd0);
    endtask

    task automatic reset_mid_fetch();
        int d0, t;
        prep_sources(2 * SOW + 3, 8, 1'b0, 0);
        d0 = done_cnt;
        pulse_start(2, 2);
        t = 0;
        while (obs_w.size() < 2 && t < 50) begin @(negedge clk); #1; t++; end
        check("rst_mid_progress", 64'(obs_w.size() >= 2), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_busy",   64'(busy), 64'd0);
        check("rst_mid_done",   64'(done), 64'd0);
        check("rst_mid_loadw",  64'(bus.o_enable_loadw), 64'd0);
        check("rst_mid_loadip", 64'(bus.o_enable_loadip), 64'd0);
        check("rst_mid_wrdy",   64'(bus.s_wght_ready), 64'd0);
        check("rst_mid_frdy",   64'(bus.s_feat_ready), 64'd0);
        check("rst_mid_wcol",   64'(bus.o_weight_col), 64'd0);
        check("rst_mid_fcol",   64'(bus.o_feature_map_col), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("post_rst_wrdy",  64'(bus.s_wght_ready), 64'd0);
        check("post_rst_busy",  64'(busy), 64'd0);
        check("post_rst_nodone", 64'(done_cnt - d0), 64'd0);
    endtask

    // --------------------------------------------------------------- main
    initial begin
        bus.i_en_prcs_new_chnl  = 1'b0;
        bus.i_en_prcs_new_wcoln = 1'b0;
        bus.i_en_fifo_loop      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_done",   64'(done), 64'd0);
        check("rst_loadw",  64'(bus.o_enable_loadw), 64'd0);
        check("rst_loadip", 64'(bus.o_enable_loadip), 64'd0);
        check("rst_wrdy",   64'(bus.s_wght_ready), 64'd0);
        check("rst_frdy",   64'(bus.s_feat_ready), 64'd0);
        check("rst_wcol",   64'(bus.o_weight_col), 64'd0);
        check("rst_fcol",   64'(bus.o_feature_map_col), 64'd0);
        rst_n = 1'b1;

        run_job(1, 2, 0, 1, 1'b0);   // 5 loadw, 2 loadip
        run_job(2, 1, 0, 1, 1'b1);   // weights 0x01..0x0A over two channels
        run_job(1, 2, 0, 2, 1'b0);   // loopback replay after kernel
        run_job(2, 2, 1, 0, 1'b0);   // valid toggling every other cycle
        run_job(2, 3, 2, 3, 1'b0);   // wcoln + new channel together at col 0
        zero_job(0, 4);
        zero_job(3, 0);
        reset_mid_fetch();
        for (int i = 0; i < 10; i++) begin
            run_job($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(0, 2), 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
